// File: rtl/d_ff.sv
// d_ff: positive-edge D flip-flop with complementary output and synchronous active-high reset
module d_ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qbar
);
  // single state bit; reset takes priority over d on the same rising edge
  always_ff @(posedge clk) q <= rst ? RESET_VALUE : d;
  assign qbar = ~q;
endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: table-driven, hand-written and randomized checks of d_ff with both reset values
module tb_d_ff;
  logic clk = 1'b0;
  logic rst, d;
  logic q0, qbar0, q1, qbar1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst;
    logic d;
    logic q0;
    logic q1;
  } vec_t;

  vec_t vecs [8];

  d_ff #(.RESET_VALUE(1'b0)) dut0 (.clk(clk), .rst(rst), .d(d), .q(q0), .qbar(qbar0));
  d_ff #(.RESET_VALUE(1'b1)) dut1 (.clk(clk), .rst(rst), .d(d), .q(q1), .qbar(qbar1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic e0, input logic e1);
    chk({name, " q0"}, q0, e0);
    chk({name, " qbar0"}, qbar0, ~e0);
    chk({name, " q1"}, q1, e1);
    chk({name, " qbar1"}, qbar1, ~e1);
  endtask

  task automatic edge_apply(input logic r, input logic dv);
    rst = r;
    d = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic m0, m1, r, dv;
    vecs[0] = '{rst: 1'b0, d: 1'b1, q0: 1'b1, q1: 1'b1};
    vecs[1] = '{rst: 1'b0, d: 1'b0, q0: 1'b0, q1: 1'b0};
    vecs[2] = '{rst: 1'b0, d: 1'b0, q0: 1'b0, q1: 1'b0};
    vecs[3] = '{rst: 1'b0, d: 1'b1, q0: 1'b1, q1: 1'b1};
    vecs[4] = '{rst: 1'b1, d: 1'b1, q0: 1'b0, q1: 1'b1};
    vecs[5] = '{rst: 1'b0, d: 1'b1, q0: 1'b1, q1: 1'b1};
    vecs[6] = '{rst: 1'b1, d: 1'b0, q0: 1'b0, q1: 1'b1};
    vecs[7] = '{rst: 1'b0, d: 1'b0, q0: 1'b0, q1: 1'b0};
    rst = 1'b1;
    d = 1'bx;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset capture", 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      edge_apply(vecs[i].rst, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].q0, vecs[i].q1);
    end
    edge_apply(1'b0, 1'b1);
    chk_all("load one", 1'b1, 1'b1);
    #3;
    chk_all("hold mid cycle", 1'b1, 1'b1);
    edge_apply(1'b0, 1'b0);
    #1 d = 1'b1;
    #1 d = 1'b0;
    #1 d = 1'b1;
    #1 d = 1'b0;
    #1;
    chk_all("d toggle between edges", 1'b0, 1'b0);
    edge_apply(1'b0, 1'b1);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_all("rst pulse between edges", 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_all("after rst pulse", 1'b1, 1'b1);
    edge_apply(1'b1, 1'b1);
    chk_all("reset priority", 1'b0, 1'b1);
    #2 rst = 1'b0;
    d = 1'b1;
    @(posedge clk);
    #1;
    chk_all("release mid cycle", 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 3) == 0);
      dv = $urandom_range(0, 1) != 0;
      m0 = r ? 1'b0 : dv;
      m1 = r ? 1'b1 : dv;
      edge_apply(r, dv);
      #2 d = ~dv;
      chk_all($sformatf("rand%0d", i), m0, m1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
